// File: rtl/wait_cond_pkg.sv
// Shared types and constants for wait_cond_driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wait_cond_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STEP      = 2'd1,
        WAIT_RESP = 2'd2,
        REPORT    = 2'd3
    } state_t;

    localparam int FAIL_W = 3;

    localparam logic [FAIL_W-1:0] FAIL_NONE    = 3'd0;
    localparam logic [FAIL_W-1:0] FAIL_TIMEOUT = 3'd7;

endpackage

// File: rtl/wcd_down_counter.sv
// Loadable down-counter with zero and last-count flags.
// Latency: load/decrement take effect on the next clock edge.
// Backpressure: none; decrement saturates at zero.
module wcd_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/wait_cond_driver.sv
// Steps value 0..TARGET (HOLD cycles each), checks responder quiet, then waits for RESP_VAL.
// Latency: done pulses the cycle after the deciding edge (match, timeout or early abort).
// Backpressure: start is only sampled in IDLE; WAIT_COND_DRIVER_EARLY_ABORT_EN ends on first premature resp.
module wait_cond_driver
    import wait_cond_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TARGET   = 3,
    parameter int HOLD     = 2,
    parameter int TIMEOUT  = 10,
    parameter int RESP_VAL = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  resp,
    output logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FAIL_W-1:0] fail_code
);

    localparam int HOLD_W = $clog2(HOLD + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_value, w_value_nxt, w_value_inc;
    logic [FAIL_W-1:0] r_fail, w_fail_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pass, w_pass_nxt;
    logic              w_hold_ld, w_hold_dec, w_hold_zero, w_hold_last;
    logic              w_to_ld, w_to_dec, w_to_zero, w_to_last;
    logic              w_premature, w_enter_rpt;

    wcd_down_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_hold_ld),
        .i_load_val (HOLD_W'(HOLD)),
        .i_dec      (w_hold_dec),
        .o_zero     (w_hold_zero),
        .o_last     (w_hold_last)
    );

    wcd_down_counter #(.W(TO_W)) u_to_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_to_ld),
        .i_load_val (TO_W'(TIMEOUT)),
        .i_dec      (w_to_dec),
        .o_zero     (w_to_zero),
        .o_last     (w_to_last)
    );

    assign w_value_inc = r_value + WIDTH'(1);
    assign w_premature = (resp != '0);

    // State register plus registered outputs; all clear on async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_value <= '0;
            r_fail  <= FAIL_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_value <= w_value_nxt;
            r_fail  <= w_fail_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Next-state and next-output logic; a zero count is treated like the last
    // count so a stuck counter can never stall the sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_value;
        w_fail_nxt  = r_fail;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_hold_ld   = 1'b0;
        w_hold_dec  = 1'b0;
        w_to_ld     = 1'b0;
        w_to_dec    = 1'b0;
        w_enter_rpt = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = STEP;
                    w_value_nxt = '0;
                    w_fail_nxt  = FAIL_NONE;
                    w_pass_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_hold_ld   = 1'b1;
                end
            end
            STEP: begin
                if (w_hold_last || w_hold_zero) begin
                    // Step code is value+1 so that 0 stays free for "no failure".
                    if (w_premature && (r_fail == FAIL_NONE)) begin
                        w_fail_nxt = FAIL_W'(w_value_inc);
                    end
`ifdef WAIT_COND_DRIVER_EARLY_ABORT_EN
                    if (w_premature) begin
                        w_enter_rpt = 1'b1;
                    end else
`endif
                    begin
                        w_value_nxt = w_value_inc;
                        if (w_value_inc == WIDTH'(TARGET)) begin
                            w_state_nxt = WAIT_RESP;
                            w_to_ld     = 1'b1;
                        end else begin
                            w_hold_ld   = 1'b1;
                        end
                    end
                end else begin
                    w_hold_dec = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (resp == WIDTH'(RESP_VAL)) begin
                    w_enter_rpt = 1'b1;
                end else if (w_to_last || w_to_zero) begin
                    if (r_fail == FAIL_NONE) begin
                        w_fail_nxt = FAIL_TIMEOUT;
                    end
                    w_enter_rpt = 1'b1;
                end else begin
                    w_to_dec = 1'b1;
                end
            end
            REPORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_enter_rpt) begin
            w_state_nxt = REPORT;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_pass_nxt  = (w_fail_nxt == FAIL_NONE);
        end
    end

    assign value     = r_value;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fail;

endmodule
